div32u16_hdr_seq: RTL and testbench

Sequential approximate unsigned divider. It is the inverse-direction companion of the mul16u_HDR truncated-operand multiplier, and accepts a 2W-bit dividend and a W-bit divisor. The low TRUNC bits of both operands are discarded, so the block divides only the high-order parts with a shift-subtract (restoring) datapath. It sits in the approximate-arithmetic library next to the HDR multipliers and uses a valid/ready handshake on both sides.

---
 rtl/div32u16_hdr_seq.sv | 111 +++++++++++
 tb/tb_div32u16_hdr_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/div32u16_hdr_seq.sv
// rtl/div32u16_hdr_seq.sv - approximate 2W/W restoring divider on truncated operands; optional HDR_DIV_ROUND_EN rounds Q to nearest
module div32u16_hdr_seq #(
    parameter int W     = 16,
    parameter int TRUNC = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   A,
    input  logic [W-1:0]     B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   Q,
    output logic [W-1:0]     R,
    output logic             DBZ
);
    localparam int NW = 2*W - TRUNC;
    localparam int DW = W - TRUNC;
    localparam int QW = 2*W;
    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, stateNext;
    logic [NW-1:0]   nrReg;
    logic [DW-1:0]   drReg;
    logic [DW-1:0]   remReg;
    logic [CW-1:0]   iterCnt;

    logic [NW-1:0]   nrIn;
    logic [DW-1:0]   drIn;
    logic [DW:0]     trial;
    logic            qBit;
    logic [DW-1:0]   remNext;
    logic [NW-1:0]   qTrunc;
    logic [QW-1:0]   qFinal;
    logic [W-1:0]    rFinal;
    logic            lastIter;
    logic [3*W-1:0]  unusedOps;

    assign nrIn      = A[2*W-1:TRUNC];
    assign drIn      = B[W-1:TRUNC];
    assign unusedOps = {A, B};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One restoring step: the quotient bit shifts into the vacated LSB of nrReg.
    always_comb begin
        trial    = {remReg, nrReg[NW-1]};
        qBit     = (trial >= {1'b0, drReg});
        remNext  = qBit ? DW'(trial - {1'b0, drReg}) : trial[DW-1:0];
        qTrunc   = {nrReg[NW-2:0], qBit};
        lastIter = (iterCnt == CW'(NW - 1));
        rFinal   = W'(remNext) << TRUNC;
`ifdef HDR_DIV_ROUND_EN
        qFinal   = QW'(qTrunc) + QW'(({remNext, 1'b0} >= {1'b0, drReg}) ? 1'b1 : 1'b0);
`else
        qFinal   = QW'(qTrunc);
`endif
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (in_valid) stateNext = (drIn == '0) ? DONE : BUSY;
            BUSY: if (lastIter) stateNext = DONE;
            DONE: if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Result registers only change when a new result loads, so they hold after a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrReg   <= '0;
            drReg   <= '0;
            remReg  <= '0;
            iterCnt <= '0;
            Q       <= '0;
            R       <= '0;
            DBZ     <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                nrReg   <= nrIn;
                drReg   <= drIn;
                remReg  <= '0;
                iterCnt <= '0;
                if (drIn == '0) begin
                    Q   <= '1;
                    R   <= '0;
                    DBZ <= 1'b1;
                end
            end else if (state == BUSY) begin
                nrReg   <= qTrunc;
                remReg  <= remNext;
                iterCnt <= iterCnt + 1'b1;
                if (lastIter) begin
                    Q   <= qFinal;
                    R   <= rFinal;
                    DBZ <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_div32u16_hdr_seq.sv
// tb/tb_div32u16_hdr_seq.sv - randomized and directed bench for div32u16_hdr_seq against an arithmetic reference
module tb_div32u16_hdr_seq;
    localparam int W     = 16;
    localparam int TRUNC = 10;

    logic            clk = 0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     A;
    logic [15:0]     B;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     Q;
    logic [15:0]     R;
    logic            DBZ;

    int vectors = 0;
    int miscompares = 0;

    div32u16_hdr_seq #(.W(W), .TRUNC(TRUNC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Q(Q), .R(R), .DBZ(DBZ)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic dbz, output int lat);
        longint nr, dr, qq, rr;
        nr = longint'(a) >> TRUNC;
        dr = longint'(b) >> TRUNC;
        if (dr == 0) begin
            q = 32'hFFFF_FFFF; r = 16'h0; dbz = 1'b1; lat = 1;
        end else begin
            qq = nr / dr;
            rr = nr % dr;
`ifdef HDR_DIV_ROUND_EN
            if (2 * rr >= dr) qq = qq + 1;
`endif
            q = qq[31:0]; r = 16'(rr << TRUNC); dbz = 1'b0; lat = 2*W - TRUNC + 1;
        end
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [15:0] b);
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = $urandom; B = 16'($urandom);
    endtask

    task automatic wait_result(output int lat, output logic irLow);
        lat = 0; irLow = 1'b1;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (in_ready !== 1'b0) irLow = 1'b0;
            if (out_valid === 1'b1) break;
        end
    endtask

    task automatic pop_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] a, input logic [15:0] b);
        logic [31:0] eq; logic [15:0] er; logic ed; int el; int lat; logic irLow;
        model(a, b, eq, er, ed, el);
        start_op(a, b);
        wait_result(lat, irLow);
        vectors += 5;
        if (lat !== el) begin miscompares++; $display("FAIL %s latency a=%h b=%h got %0d exp %0d", tag, a, b, lat, el); end
        if (Q !== eq) begin miscompares++; $display("FAIL %s Q a=%h b=%h got %h exp %h", tag, a, b, Q, eq); end
        if (R !== er) begin miscompares++; $display("FAIL %s R a=%h b=%h got %h exp %h", tag, a, b, R, er); end
        if (DBZ !== ed) begin miscompares++; $display("FAIL %s DBZ a=%h b=%h got %b exp %b", tag, a, b, DBZ, ed); end
        if (irLow !== 1'b1) begin miscompares++; $display("FAIL %s in_ready_low a=%h b=%h got %b exp 1", tag, a, b, irLow); end
        pop_result();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        vectors += 5;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
        if (Q !== 32'h0) begin miscompares++; $display("FAIL reset Q got %h exp 0", Q); end
        if (R !== 16'h0) begin miscompares++; $display("FAIL reset R got %h exp 0", R); end
        if (DBZ !== 1'b0) begin miscompares++; $display("FAIL reset DBZ got %b exp 0", DBZ); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] da [6] = '{32'h0400_0000, 32'h0000_0C00, 32'h1234_5678, 32'h0000_03FF, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [15:0] db [6] = '{16'h0400, 16'h0800, 16'h03FF, 16'h0800, 16'hFFFF, 16'h0C00};
        for (int i = 0; i < 6; i++) run_and_check("directed", da[i], db[i]);
    endtask

    task automatic test_random();
        logic [31:0] a; logic [15:0] b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = b & 16'h07FF;
                1: a = a & 32'h000F_FFFF;
                default: ;
            endcase
            run_and_check("random", a, b);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eq, eq2; logic [15:0] er, er2; logic ed, ed2; int el, el2; int lat; logic irLow;
        logic [31:0] a2; logic [15:0] b2;
        a2 = 32'h8765_4321; b2 = 16'h1C00;
        model(32'h0ABC_DEF0, 16'h0C00, eq, er, ed, el);
        model(a2, b2, eq2, er2, ed2, el2);
        start_op(32'h0ABC_DEF0, 16'h0C00);
        wait_result(lat, irLow);
        vectors += 3;
        if (lat !== el) begin miscompares++; $display("FAIL bp first latency got %0d exp %0d", lat, el); end
        if (Q !== eq) begin miscompares++; $display("FAIL bp first Q got %h exp %h", Q, eq); end
        if (R !== er) begin miscompares++; $display("FAIL bp first R got %h exp %h", R, er); end
        A = a2; B = b2; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors += 5;
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp hold out_valid cyc %0d got %b exp 1", c, out_valid); end
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp hold in_ready cyc %0d got %b exp 0", c, in_ready); end
            if (Q !== eq) begin miscompares++; $display("FAIL bp hold Q cyc %0d got %h exp %h", c, Q, eq); end
            if (R !== er) begin miscompares++; $display("FAIL bp hold R cyc %0d got %h exp %h", c, R, er); end
            if (DBZ !== ed) begin miscompares++; $display("FAIL bp hold DBZ cyc %0d got %b exp %b", c, DBZ, ed); end
        end
        pop_result();
        @(negedge clk);
        vectors += 3;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp pop out_valid got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp pop in_ready got %b exp 1", in_ready); end
        if (Q !== eq) begin miscompares++; $display("FAIL bp pop Q held got %h exp %h", Q, eq); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat, irLow);
        vectors += 4;
        if (lat !== el2) begin miscompares++; $display("FAIL bp second latency got %0d exp %0d", lat, el2); end
        if (Q !== eq2) begin miscompares++; $display("FAIL bp second Q got %h exp %h", Q, eq2); end
        if (R !== er2) begin miscompares++; $display("FAIL bp second R got %h exp %h", R, er2); end
        if (DBZ !== ed2) begin miscompares++; $display("FAIL bp second DBZ got %b exp %b", DBZ, ed2); end
        pop_result();
    endtask

    task automatic test_reset_mid_busy();
        start_op(32'hFFFF_FFFF, 16'hFFFF);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors += 5;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst out_valid got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst in_ready got %b exp 1", in_ready); end
        if (Q !== 32'h0) begin miscompares++; $display("FAIL midrst Q got %h exp 0", Q); end
        if (R !== 16'h0) begin miscompares++; $display("FAIL midrst R got %h exp 0", R); end
        if (DBZ !== 1'b0) begin miscompares++; $display("FAIL midrst DBZ got %b exp 0", DBZ); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst stale out_valid got %b exp 0", out_valid); end
        end
        run_and_check("after_reset", 32'h0400_0000, 16'h0400);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
